// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit sitting between the CPU datapath and a word-wide data
// memory. The CPU presents byte addresses with a byte/half/word size; the unit
// converts them into word-indexed memory transactions. Sub-word stores are
// performed as read-modify-write, loads are lane-extracted and sign/zero
// extended. Misaligned and out-of-range requests are reported and never touch
// memory. The memory is read combinationally on the falling edge (mem_rd is
// valid before the next rising edge) and written on the rising edge.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10/11 word
//   req_signed          loads: sign-extend when 1
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load result (0 for stores and errors)
//   resp_err            bit0 misaligned, bit1 out of range
//   mem_we/mem_addr     memory write enable and word index
//   mem_wd/mem_rd       memory write / read data
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int WIDTH    = 32,
    parameter int CAPACITY = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [1:0]       resp_err,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(CAPACITY * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    state_t           state_r;
    logic             we_r;
    logic [1:0]       size_r;
    logic             signed_r;
    logic [1:0]       off_r;
    logic [WIDTH-1:0] wdata_r;
    // Memory-side data word: raw read word on loads, merged/whole word on
    // stores. It also drives mem_wd so the write data is a plain register.
    logic [WIDTH-1:0] word_r;

    logic             misaligned_s;
    logic             out_of_range_s;
    logic [1:0]       err_s;

    // Pull the addressed lane out of a memory word and extend it.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sgn);
        logic [31:0] lane;
        lane = word >> {off, 3'b000};
        case (size)
            2'b00:   extract_lane = {{24{sgn & lane[7]}}, lane[7:0]};
            2'b01:   extract_lane = {{16{sgn & lane[15]}}, lane[15:0]};
            default: extract_lane = word;
        endcase
    endfunction

    // Replace the addressed lane of a memory word with the low store bits.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] mask;
        logic [31:0] placed;
        case (size)
            2'b00: begin
                mask   = 32'h0000_00FF << {off, 3'b000};
                placed = {24'h00_0000, data[7:0]} << {off, 3'b000};
            end
            2'b01: begin
                mask   = 32'h0000_FFFF << {off[1], 4'b0000};
                placed = {16'h0000, data[15:0]} << {off[1], 4'b0000};
            end
            default: begin
                mask   = 32'hFFFF_FFFF;
                placed = data;
            end
        endcase
        merge_lane = (word & ~mask) | (placed & mask);
    endfunction

    // Size code 11 behaves like a word, hence the test on req_size[1] alone.
    assign misaligned_s   = ((req_size == 2'b01) & req_addr[0])
                          | (req_size[1] & (req_addr[1:0] != 2'b00));
    assign out_of_range_s = (req_addr >= ADDR_LIMIT);
    assign err_s          = {out_of_range_s, misaligned_s};
    assign mem_wd         = word_r;

    // Request sequencer: accept, read, write back, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 2'b00;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            word_r     <= '0;
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            signed_r   <= 1'b0;
            off_r      <= 2'b00;
            wdata_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r      <= req_we;
                        size_r    <= req_size;
                        signed_r  <= req_signed;
                        off_r     <= req_addr[1:0];
                        wdata_r   <= req_wdata;
                        mem_addr  <= {2'b00, req_addr[WIDTH-1:2]};
                        req_ready <= 1'b0;
                        if (err_s != 2'b00) begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= err_s;
                        end else if (req_we && req_size[1]) begin
                            // Whole-word store needs no read.
                            state_r <= ST_WR;
                            mem_we  <= 1'b1;
                            word_r  <= req_wdata;
                        end else begin
                            state_r <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (we_r) begin
                        state_r <= ST_WR;
                        mem_we  <= 1'b1;
                        word_r  <= merge_lane(mem_rd, wdata_r, size_r, off_r);
                    end else begin
                        state_r    <= ST_RESP;
                        word_r     <= mem_rd;
                        resp_valid <= 1'b1;
                        resp_rdata <= extract_lane(mem_rd, size_r, off_r, signed_r);
                        resp_err   <= 2'b00;
                    end
                end
                ST_WR: begin
                    state_r    <= ST_RESP;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 2'b00;
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    mem_we     <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// Testbench for mem_access_unit. Provides a behavioural word memory (read on
// the falling edge, written on the rising edge) and a byte-array reference
// model of the CPU-visible memory. Directed scenarios plus randomized traffic
// are compared against the model.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:127];
    logic [7:0]  ref_bytes [0:511];
    logic        pre_en = 1'b0;
    logic [6:0]  pre_idx = 7'd0;
    logic [31:0] pre_data = 32'h0;

    // Observations of the last request
    int          obs_resp_cyc, obs_resp_cnt, obs_we_cnt, obs_we_cyc;
    logic [31:0] obs_we_addr, obs_we_wd, obs_rdata;
    logic [1:0]  obs_err;
    // Model expectations of the last request
    int          exp_lat, exp_nwe;
    logic [31:0] exp_wa, exp_wd, exp_rdata;
    logic [1:0]  exp_err;

    mem_access_unit #(.WIDTH(32), .CAPACITY(128)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Memory read port: falling edge
    always @(negedge clk) mem_rd <= (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 32'h0;

    // Memory write port: rising edge (DUT writes and bench preloads)
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_wd;
        if (pre_en) mem[pre_idx] <= pre_data;
    end

    task automatic preload(input int w, input logic [31:0] d);
        pre_en = 1'b1; pre_idx = 7'(w); pre_data = d;
        for (int i = 0; i < 4; i++) ref_bytes[w*4+i] = d[8*i +: 8];
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Reference model: byte-addressed memory with the architectural rules.
    task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int nb;
        int base;
        logic mis, rng;
        logic [31:0] v;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
        rng = (addr >= 32'd512);
        exp_err = {rng, mis};
        exp_rdata = 32'h0; exp_nwe = 0; exp_wa = addr >> 2; exp_wd = 32'h0;
        if (mis || rng) begin
            exp_lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[addr + i]) << (8 * i));
            if (sgn && v[8*nb-1])
                for (int i = nb; i < 4; i++) v = v | (32'hFF << (8 * i));
            exp_rdata = v;
            exp_lat = 2;
        end else begin
            for (int i = 0; i < nb; i++) ref_bytes[addr + i] = wdata[8*i +: 8];
            base = int'(addr) & ~3;
            exp_wd = {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
            exp_nwe = 1;
            exp_lat = (nb == 4) ? 2 : 3;
        end
    endtask

    // Issue one request and record 8 cycles of DUT behaviour after acceptance.
    // With hold=1, req_valid stays high with junk fields until the response.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        obs_resp_cyc = 0; obs_resp_cnt = 0; obs_we_cnt = 0; obs_we_cyc = 0;
        obs_we_addr = 32'h0; obs_we_wd = 32'h0; obs_rdata = 32'h0; obs_err = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin
                obs_we_cnt++; obs_we_cyc = c; obs_we_addr = mem_addr; obs_we_wd = mem_wd;
            end
            if (resp_valid) begin
                obs_resp_cnt++;
                if (obs_resp_cyc == 0) begin
                    obs_resp_cyc = c; obs_rdata = resp_rdata; obs_err = resp_err;
                end
            end
            if (hold && obs_resp_cyc == 0) begin
                req_valid = 1'b1; req_we = 1'b1; req_size = 2'(c % 3);
                req_addr = $urandom_range(0, 511); req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b need 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b need 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h need 0", resp_rdata); end
        checks++; if (resp_err !== 2'b00) begin errors++; $display("FAIL rst_err: got %b need 00", resp_err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b need 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h need 0", mem_addr); end
        checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL rst_mem_wd: got %h need 0", mem_wd); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        preload(3, 32'h8899AABB);
        run_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_signed: got %h need FFFFFFAA", obs_rdata); end
        checks++; if (obs_resp_cyc !== 2) begin errors++; $display("FAIL lb_latency: got %0d need 2", obs_resp_cyc); end
        checks++; if (obs_err !== 2'b00) begin errors++; $display("FAIL lb_err: got %b need 00", obs_err); end
        checks++; if (obs_we_cnt !== 0) begin errors++; $display("FAIL lb_no_write: got %0d writes need 0", obs_we_cnt); end
        run_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'h00008899) begin errors++; $display("FAIL lhu: got %h need 00008899", obs_rdata); end
        run_req(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'hFFFFAABB) begin errors++; $display("FAIL lh_signed: got %h need FFFFAABB", obs_rdata); end
        run_req(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'h00000088) begin errors++; $display("FAIL lbu_top: got %h need 00000088", obs_rdata); end
    endtask

    task automatic test_subword_store();
        preload(3, 32'h8899AABB);
        model_req(1'b1, 2'b00, 1'b0, 32'h0E, 32'h00000055);
        run_req(1'b1, 2'b00, 1'b0, 32'h0E, 32'h00000055, 1'b0);
        checks++; if (obs_we_cnt !== 1) begin errors++; $display("FAIL sb_we_count: got %0d need 1", obs_we_cnt); end
        checks++; if (obs_we_cyc !== 2) begin errors++; $display("FAIL sb_we_cycle: got %0d need 2", obs_we_cyc); end
        checks++; if (obs_we_addr !== 32'd3) begin errors++; $display("FAIL sb_addr: got %h need 3", obs_we_addr); end
        checks++; if (obs_we_wd !== 32'h8855AABB) begin errors++; $display("FAIL sb_wd: got %h need 8855AABB", obs_we_wd); end
        checks++; if (obs_resp_cyc !== 3) begin errors++; $display("FAIL sb_latency: got %0d need 3", obs_resp_cyc); end
        checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h need 0", obs_rdata); end
    endtask

    task automatic test_word_store();
        model_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        checks++; if (obs_we_cyc !== 1 || obs_we_cnt !== 1) begin errors++; $display("FAIL sw_we: cycle %0d count %0d need cycle 1 count 1", obs_we_cyc, obs_we_cnt); end
        checks++; if (obs_we_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wd: got %h need DEADBEEF", obs_we_wd); end
        checks++; if (obs_we_addr !== 32'd4) begin errors++; $display("FAIL sw_addr: got %h need 4", obs_we_addr); end
        checks++; if (obs_resp_cyc !== 2) begin errors++; $display("FAIL sw_latency: got %0d need 2", obs_resp_cyc); end
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_readback: got %h need DEADBEEF", obs_rdata); end
    endtask

    task automatic test_errors();
        run_req(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b0);
        checks++; if (obs_err !== 2'b01) begin errors++; $display("FAIL misaligned_err: got %b need 01", obs_err); end
        checks++; if (obs_resp_cyc !== 1) begin errors++; $display("FAIL misaligned_latency: got %0d need 1", obs_resp_cyc); end
        checks++; if (obs_we_cnt !== 0 || obs_rdata !== 32'h0) begin errors++; $display("FAIL misaligned_side: writes %0d rdata %h need 0 0", obs_we_cnt, obs_rdata); end
        run_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 1'b0);
        checks++; if (obs_err !== 2'b10) begin errors++; $display("FAIL range_err: got %b need 10", obs_err); end
        checks++; if (obs_we_cnt !== 0) begin errors++; $display("FAIL range_no_write: got %0d need 0", obs_we_cnt); end
        run_req(1'b1, 2'b11, 1'b0, 32'h1FE, 32'h0, 1'b0);
        checks++; if (obs_err !== 2'b01 || obs_we_cnt !== 0) begin errors++; $display("FAIL size3_misaligned: err %b writes %0d need 01 0", obs_err, obs_we_cnt); end
    endtask

    task automatic test_reset_mid();
        int bad;
        preload(5, 32'h11223344);
        preload(6, 32'hA5A55A5A);
        // Reset during the read cycle of a byte store: abandoned entirely.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h15; req_wdata = 32'hEE;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstrd_ready: got %b need 1", req_ready); end
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_we || resp_valid) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstrd_quiet: got %0d active cycles need 0", bad); end
        run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'h11223344) begin errors++; $display("FAIL rstrd_unmodified: got %h need 11223344", obs_rdata); end
        // Reset during the write cycle of a half store: the write still lands.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h1A; req_wdata = 32'h00007777;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstwr_we: got %b need 1", mem_we); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_req(1'b1, 2'b01, 1'b0, 32'h1A, 32'h00007777);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_we || resp_valid || !req_ready) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstwr_quiet: got %0d active cycles need 0", bad); end
        run_req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 1'b0);
        checks++; if (obs_rdata !== 32'h77775A5A) begin errors++; $display("FAIL rstwr_landed: got %h need 77775A5A", obs_rdata); end
    endtask

    task automatic test_random();
        logic        we, sgn;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        bit          hold;
        for (int k = 0; k < 200; k++) begin
            we = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3)); wdata = $urandom;
            hold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) addr = $urandom_range(512, 4000);
            else addr = $urandom_range(0, 511);
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
            model_req(we, size, sgn, addr, wdata);
            run_req(we, size, sgn, addr, wdata, hold);
            checks++;
            if (obs_resp_cyc !== exp_lat || obs_resp_cnt !== 1) begin
                errors++; $display("FAIL rnd_resp #%0d: cycle %0d count %0d need cycle %0d count 1", k, obs_resp_cyc, obs_resp_cnt, exp_lat);
            end
            checks++;
            if (obs_err !== exp_err || obs_rdata !== exp_rdata) begin
                errors++; $display("FAIL rnd_data #%0d addr %h: err %b rdata %h need err %b rdata %h", k, addr, obs_err, obs_rdata, exp_err, exp_rdata);
            end
            checks++;
            if (obs_we_cnt !== exp_nwe) begin
                errors++; $display("FAIL rnd_we_count #%0d: got %0d need %0d", k, obs_we_cnt, exp_nwe);
            end else if (exp_nwe == 1) begin
                checks++;
                if (obs_we_cyc !== exp_lat - 1 || obs_we_addr !== exp_wa || obs_we_wd !== exp_wd) begin
                    errors++; $display("FAIL rnd_write #%0d: cyc %0d addr %h wd %h need cyc %0d addr %h wd %h", k, obs_we_cyc, obs_we_addr, obs_we_wd, exp_lat - 1, exp_wa, exp_wd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        for (int w = 0; w < 128; w++) preload(w, $urandom);
        test_loads();
        test_subword_store();
        test_word_store();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the CPU datapath and the word-wide data memory: CPU side gives byte addresses with byte/half/word size; memory side gives word index, 32-bit write data and write enable.
- Sub-word stores use read-modify-write (read, merge, write back); loads are extracted and sign/zero-extended.
- Misaligned and out-of-range accesses are caught and never reach memory.
- Memory is read-only on the falling edge (mem_rd valid by the next rising edge) and written on the rising edge.

Parameters:
- WIDTH, 32, data/address width (fixed at 32).
- CAPACITY, 128, memory depth in words; byte addresses >= CAPACITY*4 are out of range.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  CPU request strobe, sampled only when req_ready=1.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result (0 for stores and errors).
- resp_err  out  2  bit0 misaligned, bit1 out of range; valid with resp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word index = latched addr >> 2, upper bits 0.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data.

Behaviour:
- Little-endian lanes: byte k = addr[1:0] occupies bits [8k+7:8k]; half at addr[1]=h occupies [16h+15:16h].
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields and compute errors.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Range: addr >= CAPACITY*4.
  - Any error -> RESP with resp_err set; memory untouched.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RD.
- RD: mem_addr = word index, mem_we=0. At the closing edge, capture mem_rd into word_q.
  - Load -> RESP, with resp_rdata = extracted lane, extended per req_signed.
  - Store -> WR.
- WR: mem_we=1 for exactly one cycle.
  - Word store: mem_wd = req_wdata.
  - Sub-word store: mem_wd = word_q with the selected lane replaced by the low 8/16 bits of req_wdata; other lanes unchanged.
  - Next state RESP.
- RESP: resp_valid=1 for one cycle; resp_rdata holds the load result, else 0. Next state IDLE. req_ready=0.
- Outside the states that drive them: mem_we=0, resp_valid=0; resp_rdata and resp_err hold their last values.
- Latency from the accepting edge T:
  - error: resp_valid in cycle T+1.
  - load and word store: T+2.
  - sub-word store: T+3.
- Throughput: one request per RESP→IDLE round trip; req_valid held while req_ready=0 is ignored, not queued.
- mem_we is a decode of state WR; mem_addr/mem_wd come from latched registers and are stable for the whole cycle.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0, word_q=0.
- Reset mid-operation: the request is abandoned and no resp_valid is issued. If rst is sampled at the closing edge of a WR cycle, that write still lands in memory (same edge); no other write occurs.
- resp_rdata for a zero-extended byte load: upper 24 bits 0. Sign-extended: upper bits = bit 7 (byte) or bit 15 (half).

Test Plan:
- Preload word 3 = 0x8899AABB; load byte signed at addr 0x0D -> resp_rdata=0xFFFFFFAA at T+2, resp_err=0, mem_we never high.
- Same word; load half unsigned at addr 0x0E -> resp_rdata=0x00008899; load half signed at 0x0C -> 0xFFFFAABB.
- Preload word 3 = 0x8899AABB; store byte 0x55 at addr 0x0E -> exactly one mem_we pulse at T+2 with mem_addr=3, mem_wd=0x8855AABB; resp_valid at T+3.
- Word store 0xDEADBEEF at addr 0x10 -> mem_we at T+1, mem_wd=0xDEADBEEF, mem_addr=4; readback load returns 0xDEADBEEF.
- Half load at 0x05 -> resp_err=01 at T+1; word store at 0x200 (CAPACITY=128) -> resp_err=10; in both cases mem_we stays 0.
- Sub-word store with rst asserted during its RD cycle -> no mem_we, no resp_valid, req_ready=1 on the next cycle; a following load of the same word returns the unmodified value.
